spi_flash_arbiter: RTL and testbench

- Shares the single ULX3S configuration SPI flash between two SPI masters:
  - port A: the tinyfpga bootloader SPI engine.
  - port B: a secondary master, e.g. a user/ESP32 flash-passthrough.
- Grants ownership through a req/gnt handshake and muxes the owner's pins onto flash_csn/flash_mosi/flash_clk.
- Enforces a CS-high guard time between owners and revokes a grant held too long.
- Sits between the masters and the flash pins in the board top, clocked on clk_48mhz.

---
 rtl/spi_flash_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arbiter
// Brief    : Shares one configuration SPI flash between two SPI masters using
//            a req/gnt handshake, a CS-high guard gap and a hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter #(
    parameter int unsigned GUARD_CYCLES = 8,
    parameter logic [23:0] MAX_HOLD     = 24'd12000000,
    parameter bit          ROUND_ROBIN  = 1'b0
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic a_req,
    output logic a_gnt,
    input  logic a_cs,
    input  logic a_mosi,
    input  logic a_sck,
    output logic a_miso,
    input  logic b_req,
    output logic b_gnt,
    input  logic b_cs,
    input  logic b_mosi,
    input  logic b_sck,
    output logic b_miso,
    output logic flash_csn,
    output logic flash_mosi,
    output logic flash_clk,
    input  logic flash_miso,
    output logic timeout_err,
    output logic busy
);

    localparam logic [1:0]  c_st_idle    = 2'd0;
    localparam logic [1:0]  c_st_own_a   = 2'd1;
    localparam logic [1:0]  c_st_own_b   = 2'd2;
    localparam logic [1:0]  c_st_guard   = 2'd3;
    localparam logic [15:0] c_guard_last = 16'(GUARD_CYCLES - 1);
    localparam logic [23:0] c_hold_last  = MAX_HOLD - 24'd1;
    localparam bit          c_timeout_en = (MAX_HOLD != 24'd0);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [23:0] r_hold_cnt;
    logic [15:0] r_guard_cnt;
    logic        r_timeout_err;
    logic        r_a_need_rel;
    logic        r_b_need_rel;
    logic        r_last_a;
    logic        w_a_eligible;
    logic        w_b_eligible;
    logic        w_hold_expire;
    logic        w_pick_b;
    logic        w_a_timeout;
    logic        w_b_timeout;

    // A port revoked by timeout stays ineligible until it lets go of req once.
    assign w_a_eligible  = a_req & ~r_a_need_rel;
    assign w_b_eligible  = b_req & ~r_b_need_rel;
    assign w_hold_expire = c_timeout_en && (r_hold_cnt == c_hold_last);
    assign w_pick_b      = ROUND_ROBIN ? r_last_a : 1'b0;
    assign w_a_timeout   = (r_state == c_st_own_a) && a_req && w_hold_expire;
    assign w_b_timeout   = (r_state == c_st_own_b) && b_req && w_hold_expire;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_a_eligible && w_b_eligible) begin
                    w_state_nxt = w_pick_b ? c_st_own_b : c_st_own_a;
                end else if (w_a_eligible) begin
                    w_state_nxt = c_st_own_a;
                end else if (w_b_eligible) begin
                    w_state_nxt = c_st_own_b;
                end
            end
            c_st_own_a: begin
                if (!a_req || w_hold_expire) begin
                    w_state_nxt = c_st_guard;
                end
            end
            c_st_own_b: begin
                if (!b_req || w_hold_expire) begin
                    w_state_nxt = c_st_guard;
                end
            end
            c_st_guard: begin
                if (r_guard_cnt == c_guard_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_hold_cnt    <= 24'd0;
            r_guard_cnt   <= 16'd0;
            r_timeout_err <= 1'b0;
            r_a_need_rel  <= 1'b0;
            r_b_need_rel  <= 1'b0;
            r_last_a      <= 1'b0;
        end else begin
            if ((r_state == c_st_own_a) || (r_state == c_st_own_b)) begin
                r_hold_cnt <= r_hold_cnt + 24'd1;
            end else begin
                r_hold_cnt <= 24'd0;
            end

            if (r_state == c_st_guard) begin
                r_guard_cnt <= r_guard_cnt + 16'd1;
            end else begin
                r_guard_cnt <= 16'd0;
            end

            if (w_a_timeout || w_b_timeout) begin
                r_timeout_err <= 1'b1;
            end

            if (w_a_timeout) begin
                r_a_need_rel <= 1'b1;
            end else if (!a_req) begin
                r_a_need_rel <= 1'b0;
            end

            if (w_b_timeout) begin
                r_b_need_rel <= 1'b1;
            end else if (!b_req) begin
                r_b_need_rel <= 1'b0;
            end

            if ((r_state == c_st_idle) && (w_state_nxt == c_st_own_a)) begin
                r_last_a <= 1'b1;
            end else if ((r_state == c_st_idle) && (w_state_nxt == c_st_own_b)) begin
                r_last_a <= 1'b0;
            end
        end
    end

    // Pins follow the registered owner with no extra latency; everyone else sees idle.
    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        flash_csn  = 1'b1;
        flash_mosi = 1'b0;
        flash_clk  = 1'b0;
        a_miso     = 1'b1;
        b_miso     = 1'b1;
        case (r_state)
            c_st_own_a: begin
                a_gnt      = 1'b1;
                flash_csn  = a_cs;
                flash_mosi = a_mosi;
                flash_clk  = a_sck;
                a_miso     = flash_miso;
            end
            c_st_own_b: begin
                b_gnt      = 1'b1;
                flash_csn  = b_cs;
                flash_mosi = b_mosi;
                flash_clk  = b_sck;
                b_miso     = flash_miso;
            end
            default: ;
        endcase
    end

    assign busy        = (r_state != c_st_idle);
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_arbiter
// Brief    : Directed self-checking bench for spi_flash_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_arbiter;

    logic clk_48mhz = 1'b0;
    logic reset     = 1'b1;
    logic a_req = 1'b0, a_cs = 1'b1, a_mosi = 1'b0, a_sck = 1'b0;
    logic b_req = 1'b0, b_cs = 1'b1, b_mosi = 1'b0, b_sck = 1'b0;
    logic flash_miso = 1'b0;

    logic a_gnt, b_gnt, a_miso, b_miso, flash_csn, flash_mosi, flash_clk, timeout_err, busy;
    logic rr_a_gnt, rr_b_gnt, rr_a_miso, rr_b_miso, rr_csn, rr_mosi, rr_clk, rr_err, rr_busy;

    int compared   = 0;
    int mismatched = 0;
    int overlap    = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    spi_flash_arbiter #(.GUARD_CYCLES(8), .MAX_HOLD(24'd100), .ROUND_ROBIN(1'b0)) u_dut (
        .clk_48mhz(clk_48mhz), .reset(reset),
        .a_req(a_req), .a_gnt(a_gnt), .a_cs(a_cs), .a_mosi(a_mosi), .a_sck(a_sck), .a_miso(a_miso),
        .b_req(b_req), .b_gnt(b_gnt), .b_cs(b_cs), .b_mosi(b_mosi), .b_sck(b_sck), .b_miso(b_miso),
        .flash_csn(flash_csn), .flash_mosi(flash_mosi), .flash_clk(flash_clk),
        .flash_miso(flash_miso), .timeout_err(timeout_err), .busy(busy)
    );

    spi_flash_arbiter #(.GUARD_CYCLES(8), .MAX_HOLD(24'd0), .ROUND_ROBIN(1'b1)) u_rr (
        .clk_48mhz(clk_48mhz), .reset(reset),
        .a_req(a_req), .a_gnt(rr_a_gnt), .a_cs(a_cs), .a_mosi(a_mosi), .a_sck(a_sck), .a_miso(rr_a_miso),
        .b_req(b_req), .b_gnt(rr_b_gnt), .b_cs(b_cs), .b_mosi(b_mosi), .b_sck(b_sck), .b_miso(rr_b_miso),
        .flash_csn(rr_csn), .flash_mosi(rr_mosi), .flash_clk(rr_clk),
        .flash_miso(flash_miso), .timeout_err(rr_err), .busy(rr_busy)
    );

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
        if ((a_gnt && b_gnt) || (rr_a_gnt && rr_b_gnt)) overlap++;
    endtask

    task automatic do_reset();
        a_req = 1'b0; a_cs = 1'b1; a_mosi = 1'b0; a_sck = 1'b0;
        b_req = 1'b0; b_cs = 1'b1; b_mosi = 1'b0; b_sck = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({a_gnt, b_gnt, busy, timeout_err} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_gnt_busy_err: got %b expected 0000", {a_gnt, b_gnt, busy, timeout_err});
        end
        compared++;
        if ({flash_csn, flash_clk, flash_mosi} !== 3'b100) begin
            mismatched++;
            $display("FAIL reset_flash_pins: got %b expected 100", {flash_csn, flash_clk, flash_mosi});
        end
        compared++;
        if ({a_miso, b_miso} !== 2'b11) begin
            mismatched++;
            $display("FAIL reset_miso: got %b expected 11", {a_miso, b_miso});
        end
    endtask

    task automatic test_grant_a();
        do_reset();
        a_req = 1'b1;
        tick();
        compared++;
        if ({a_gnt, b_gnt, busy} !== 3'b101) begin
            mismatched++;
            $display("FAIL grant_a: got a_gnt/b_gnt/busy=%b expected 101", {a_gnt, b_gnt, busy});
        end
        a_cs = 1'b0; a_mosi = 1'b1; a_sck = 1'b1; flash_miso = 1'b0;
        #1;
        compared++;
        if ({flash_csn, flash_mosi, flash_clk, a_miso, b_miso} !== 5'b01101) begin
            mismatched++;
            $display("FAIL grant_a_mux_hi: got %b expected 01101",
                     {flash_csn, flash_mosi, flash_clk, a_miso, b_miso});
        end
        a_sck = 1'b0; a_mosi = 1'b0;
        #1;
        compared++;
        if ({flash_mosi, flash_clk} !== 2'b00) begin
            mismatched++;
            $display("FAIL grant_a_mux_lo: got %b expected 00", {flash_mosi, flash_clk});
        end
        // B must neither preempt nor leak onto the pins.
        b_req = 1'b1; b_cs = 1'b0; b_sck = 1'b1; a_cs = 1'b1;
        tick();
        tick();
        compared++;
        if ({a_gnt, b_gnt, flash_csn, flash_clk} !== 4'b1010) begin
            mismatched++;
            $display("FAIL no_preempt: got a_gnt/b_gnt/csn/clk=%b expected 1010",
                     {a_gnt, b_gnt, flash_csn, flash_clk});
        end
    endtask

    task automatic test_simultaneous_guard();
        int hi;
        int bad;
        int waitc;
        do_reset();
        a_req = 1'b1; b_req = 1'b1; b_cs = 1'b0;
        tick();
        compared++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            mismatched++;
            $display("FAIL simul_fixed_prio: got a_gnt/b_gnt=%b expected 10", {a_gnt, b_gnt});
        end
        a_cs = 1'b0; flash_miso = 1'b0;
        tick();
        a_req = 1'b0;
        tick();
        compared++;
        if ({a_gnt, flash_csn} !== 2'b01) begin
            mismatched++;
            $display("FAIL release_csn: got a_gnt/csn=%b expected 01", {a_gnt, flash_csn});
        end
        hi = 1; bad = 0; waitc = 0;
        while (!b_gnt && waitc < 40) begin
            if ((flash_csn !== 1'b1) || (a_miso !== 1'b1) || (b_miso !== 1'b1)) bad++;
            tick();
            waitc++;
            if (!b_gnt) hi++;
        end
        compared++;
        if (hi !== 9 || !b_gnt) begin
            mismatched++;
            $display("FAIL guard_len: got %0d csn-high cycles (b_gnt=%b) expected 9", hi, b_gnt);
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL guard_idle_pins: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_round_robin();
        logic exp_b;
        int waitc;
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        exp_b = 1'b0;
        for (int g = 0; g < 4; g++) begin
            waitc = 0;
            while (!rr_a_gnt && !rr_b_gnt && waitc < 40) begin
                tick();
                waitc++;
            end
            compared++;
            if ({rr_a_gnt, rr_b_gnt} !== {~exp_b, exp_b}) begin
                mismatched++;
                $display("FAIL rr_order[%0d]: got a_gnt/b_gnt=%b expected %b",
                         g, {rr_a_gnt, rr_b_gnt}, {~exp_b, exp_b});
            end
            for (int c = 1; c < 20; c++) tick();
            if (exp_b) b_req = 1'b0; else a_req = 1'b0;
            tick();
            a_req = 1'b1; b_req = 1'b1;
            exp_b = ~exp_b;
        end
        compared++;
        if (overlap !== 0) begin
            mismatched++;
            $display("FAIL gnt_overlap: got %0d cycles expected 0", overlap);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        int regrant;
        do_reset();
        b_req = 1'b1;
        tick();
        cnt = 0;
        while (b_gnt && cnt < 200) begin
            cnt++;
            tick();
        end
        compared++;
        if (cnt !== 100) begin
            mismatched++;
            $display("FAIL timeout_hold: got %0d cycles expected 100", cnt);
        end
        compared++;
        if ({timeout_err, flash_csn, busy, b_gnt} !== 4'b1110) begin
            mismatched++;
            $display("FAIL timeout_state: got err/csn/busy/b_gnt=%b expected 1110",
                     {timeout_err, flash_csn, busy, b_gnt});
        end
        regrant = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (b_gnt) regrant++;
        end
        compared++;
        if (regrant !== 0) begin
            mismatched++;
            $display("FAIL timeout_no_regrant: got %0d grant cycles expected 0", regrant);
        end
        a_req = 1'b1;
        tick();
        compared++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            mismatched++;
            $display("FAIL other_port_meanwhile: got a_gnt/b_gnt=%b expected 10", {a_gnt, b_gnt});
        end
        a_req = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        compared++;
        if (b_gnt !== 1'b0) begin
            mismatched++;
            $display("FAIL still_needs_release: got b_gnt=%b expected 0", b_gnt);
        end
        b_req = 1'b0;
        tick();
        b_req = 1'b1;
        tick();
        compared++;
        if ({b_gnt, timeout_err} !== 2'b11) begin
            mismatched++;
            $display("FAIL regrant_after_toggle: got b_gnt/err=%b expected 11", {b_gnt, timeout_err});
        end
    endtask

    task automatic test_reset_mid();
        // Continues from test_timeout: B owns and the sticky error is set.
        b_cs = 1'b0; b_sck = 1'b1;
        tick();
        compared++;
        if ({b_gnt, flash_csn, flash_clk} !== 3'b101) begin
            mismatched++;
            $display("FAIL mid_xfer_pins: got b_gnt/csn/clk=%b expected 101", {b_gnt, flash_csn, flash_clk});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++;
        if ({b_gnt, flash_csn, flash_clk, timeout_err, busy} !== 5'b01000) begin
            mismatched++;
            $display("FAIL reset_mid: got b_gnt/csn/clk/err/busy=%b expected 01000",
                     {b_gnt, flash_csn, flash_clk, timeout_err, busy});
        end
    endtask

    initial begin
        test_reset();
        test_grant_a();
        test_simultaneous_guard();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
